// File: rtl/frame_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : frame_pkg                                                     |
// | Description: Shared types for the frame receiver: FSM state encoding,      |
// |              header length type and a checksum fold helper.                |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package frame_pkg;

  // Header carries the payload length in its low byte.
  localparam int LEN_W = 8;
  typedef logic [LEN_W-1:0] length_t;

  // Widest word the checksum helper handles; callers cast down to their width.
  localparam int CSUM_MAX_W = 64;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_PAY  = 3'd1,
    S_CSUM = 3'd2,
    S_SEND = 3'd3,
    S_DROP = 3'd4
  } state_e;

  typedef state_e state_t;

  // One step of the running frame checksum: XOR-accumulate a word.
  function automatic logic [CSUM_MAX_W-1:0] frame_csum(
    input logic [CSUM_MAX_W-1:0] acc,
    input logic [CSUM_MAX_W-1:0] word
  );
    return acc ^ word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rx_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : frame_rx_buf                                                  |
// | Description: DEPTH x DW register file holding one frame's payload.         |
// |              Single write port, registered read port (resets to zero).     |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module frame_rx_buf
  import frame_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Payload storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the downstream data output, so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : frame_rx                                                      |
// | Description: Store-and-forward receiver for header/payload/checksum        |
// |              frames. Buffers the payload, verifies the XOR checksum and    |
// |              forwards good payload with a last marker; bad frames produce  |
// |              a single-cycle err pulse.                                     |
// |              Optional macro FRAME_RX_STATS_EN adds ok_cnt / err_cnt.       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module frame_rx
  import frame_pkg::*;
#(
  parameter int DW      = 16,
  parameter int MAX_LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          err
`ifdef FRAME_RX_STATS_EN
  ,
  output logic [15:0]   ok_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [LEN_W:0] MAX_LEN_V = (LEN_W+1)'(MAX_LEN);

  state_t            state;
  length_t           len;
  logic [DW-1:0]     csum;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [LEN_W:0]    skip;

  logic              in_fire;
  logic              out_fire;
  length_t           hdr_len;
  length_t           len_m1;
  length_t           wptr_ext;
  length_t           rptr_ext;
  length_t           rnext_ext;
  logic              csum_ok;
  logic              wr_en;
  logic              rd_en;
  logic [PW-1:0]     rd_addr;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign hdr_len  = in_data[LEN_W-1:0];
  assign len_m1   = len - length_t'(1);
  assign csum_ok  = (in_data == csum);

  // Zero-extend pointers so every length comparison uses the full 8-bit N.
  always_comb begin
    wptr_ext           = '0;
    wptr_ext[PW-1:0]   = wptr;
    rptr_ext           = '0;
    rptr_ext[PW-1:0]   = rptr;
    rnext_ext          = rptr_ext + length_t'(1);
  end

  // Buffer port control: write during payload, prefetch word 0 on a good checksum
  // and the next word on each non-final output transfer.
  always_comb begin
    wr_en   = (state == S_PAY) && in_fire;
    rd_en   = 1'b0;
    rd_addr = '0;
    if ((state == S_CSUM) && in_fire && csum_ok) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if ((state == S_SEND) && out_fire && !out_last) begin
      rd_en   = 1'b1;
      rd_addr = rptr + PW'(1);
    end
  end

  frame_rx_buf #(
    .DW    (DW),
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  // Frame FSM with registered handshake, last and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      csum      <= '0;
      wptr      <= '0;
      rptr      <= '0;
      skip      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_HDR: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            len  <= hdr_len;
            csum <= in_data;
            wptr <= '0;
            if (hdr_len == length_t'(0)) begin
              err <= 1'b1;
            end else if ({1'b0, hdr_len} > MAX_LEN_V) begin
              err   <= 1'b1;
              skip  <= {1'b0, hdr_len} + (LEN_W+1)'(1);
              state <= S_DROP;
            end else begin
              state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (in_fire) begin
            wptr <= wptr + PW'(1);
            csum <= csum ^ in_data;
            if (wptr_ext == len_m1) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (in_fire) begin
            if (csum_ok) begin
              state     <= S_SEND;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              rptr      <= '0;
              out_last  <= (len == length_t'(1));
            end else begin
              err   <= 1'b1;
              state <= S_HDR;
            end
          end
        end
        S_SEND: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_HDR;
            end else begin
              rptr     <= rptr + PW'(1);
              out_last <= (rnext_ext == len_m1);
            end
          end
        end
        S_DROP: begin
          if (in_fire) begin
            skip <= skip - (LEN_W+1)'(1);
            if (skip == (LEN_W+1)'(1)) begin
              state <= S_HDR;
            end
          end
        end
        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

`ifdef FRAME_RX_STATS_EN
  // Saturating counters of delivered frames and rejected frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (out_fire && out_last && (ok_cnt != 16'hFFFF)) begin
        ok_cnt <= ok_cnt + 16'd1;
      end
      if (err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_frame_rx                                                   |
// | Description: Self-checking bench for frame_rx: frame-level reference       |
// |              model, per-cycle output compare, directed frame vectors.      |
// |              Build with FRAME_RX_STATS_EN to also check the counters.      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_frame_rx;
  import frame_pkg::*;

  localparam int DW      = 16;
  localparam int MAX_LEN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err;
`ifdef FRAME_RX_STATS_EN
  logic [15:0]   ok_cnt;
  logic [15:0]   err_cnt;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int            tests = 0;
  int            fails = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] fr[$];
  int            exp_err  = 0;
  int            err_seen = 0;
  int            exp_ok   = 0;
  beat_t         cmp_b;

  frame_rx #(
    .DW      (DW),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
`ifdef FRAME_RX_STATS_EN
    ,
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Frame-level model: decide the fate of a whole frame from its words.
  task automatic model_frame(input logic [DW-1:0] f[$]);
    int n;
    logic [DW-1:0] x;
    n = int'(f[0][7:0]);
    if (n == 0 || n > MAX_LEN) begin
      exp_err++;
      return;
    end
    x = '0;
    for (int i = 0; i <= n; i++) x = DW'(frame_csum(CSUM_MAX_W'(x), CSUM_MAX_W'(f[i])));
    if (x !== f[n+1]) begin
      exp_err++;
      return;
    end
    for (int i = 1; i <= n; i++) exp_q.push_back('{data: f[i], last: (i == n)});
    exp_ok++;
  endtask

  // Per-cycle compare of DUT outputs against the model queue.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          fire_prev_nl = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev   = 1'b0;
      fire_prev_nl = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, stall_data);
      end
      if (fire_prev_nl) check("no_bubble", out_valid, 1);
      if (out_valid) begin
        check("in_ready_low_in_send", in_ready, 0);
        check("err_low_in_send", err, 0);
      end
      if (err) err_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        cmp_b = exp_q.pop_front();
        check("out_data", out_data, cmp_b.data);
        check("out_last", out_last, cmp_b.last);
      end
      stall_prev   = out_valid && !out_ready;
      stall_data   = out_data;
      fire_prev_nl = out_valid && out_ready && !out_last;
    end
  end

  task automatic send_word(input logic [DW-1:0] w);
    int   t;
    logic acc;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) fail_now("in_accept_timeout");
  endtask

  task automatic send_frame(input logic [DW-1:0] f[$]);
    model_frame(f);
    foreach (f[i]) send_word(f[i]);
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int t;
    t = 0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("first_word_latency", out_valid, 1);
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
      else out_ready = 1'b1;
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) fail_now("drain_timeout");
    out_ready = 1'b1;
  endtask

  task automatic expect_err_pulse();
    @(negedge clk);
    check("err_pulse_high", err, 1);
    @(negedge clk);
    check("err_pulse_width", err, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    idle(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("in_ready_after_rst", in_ready, 1);

    // Good 3-word frame; literal pins on the model's decision
    obs_q.delete();
    fr = '{16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h0003};
    send_frame(fr);
    check("model_pin_len", exp_q.size(), 3);
    check("model_pin_last", exp_q[2].last, 1);
    check("model_pin_notlast", exp_q[0].last, 0);
    drain(0);
    check("good_count", obs_q.size(), 3);
    check("good_w0", obs_q[0], 16'h0011);
    check("good_w1", obs_q[1], 16'h0022);
    check("good_w2", obs_q[2], 16'h0033);
    check("good_no_err", err_seen, 0);
    idle(2);

    // Bad checksum, then the good frame again
    fr = '{16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h0004};
    send_frame(fr);
    check("model_pin_bad", exp_q.size(), 0);
    expect_err_pulse();
    idle(2);
    check("bad_csum_err_count", err_seen, 1);
    obs_q.delete();
    fr = '{16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h0003};
    send_frame(fr);
    drain(0);
    check("after_bad_count", obs_q.size(), 3);
    check("after_bad_w2", obs_q[2], 16'h0033);
    idle(2);

    // Zero length, then oversize with 10 dropped words, then a 1-word frame
    fr = '{16'h0000};
    send_frame(fr);
    expect_err_pulse();
    idle(1);
    fr = '{16'h0009};
    for (int i = 0; i < 10; i++) fr.push_back(16'h0100 + DW'(i));
    send_frame(fr);
    idle(3);
    check("drop_err_count", err_seen, 3);
    obs_q.delete();
    fr = '{16'h0001, 16'h00AA, 16'h00AB};
    send_frame(fr);
    drain(0);
    check("post_drop_count", obs_q.size(), 1);
    check("post_drop_w0", obs_q[0], 16'h00AA);
    idle(2);

    // Full-length frame with toggling backpressure; checksum 0x0008 ^ 0x0808
    obs_q.delete();
    fr = '{16'h0008};
    for (int i = 1; i <= 8; i++) fr.push_back(16'h0101 * DW'(i));
    fr.push_back(16'h0800);
    send_frame(fr);
    check("model_pin_full", exp_q.size(), 8);
    drain(1);
    check("bp_count", obs_q.size(), 8);
    check("bp_first", obs_q[0], 16'h0101);
    check("bp_last", obs_q[7], 16'h0808);
    idle(2);

    // Reset in the middle of a payload
    send_word(16'h0003);
    send_word(16'h0011);
    send_word(16'h0022);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("midrst_in_ready_back", in_ready, 1);
    obs_q.delete();
    fr = '{16'h0001, 16'h0055, 16'h0054};
    send_frame(fr);
    drain(0);
    check("post_rst_count", obs_q.size(), 1);
    check("post_rst_w0", obs_q[0], 16'h0055);
    idle(2);

    // Two more good and two bad frames since the reset (3 good + 2 bad)
    fr = '{16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h0003};
    send_frame(fr);
    drain(0);
    idle(1);
    fr = '{16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h0004};
    send_frame(fr);
    expect_err_pulse();
    idle(1);
    fr = '{16'h0001, 16'h00AA, 16'h00AB};
    send_frame(fr);
    drain(0);
    idle(1);
    fr = '{16'h0000};
    send_frame(fr);
    expect_err_pulse();
    idle(3);

    check("final_err_count", err_seen, exp_err);
    check("final_queue_empty", exp_q.size(), 0);
`ifdef FRAME_RX_STATS_EN
    check("stats_ok_cnt", ok_cnt, 3);
    check("stats_err_cnt", err_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_rx.md
Name: frame_rx

Overview:
- Receiving end of the framed word stream produced by sub1 inside top.
- Accepts header / payload / checksum frames over a valid/ready interface and buffers the payload in local storage.
- Verifies the XOR checksum, then forwards verified payload downstream with a last marker (store-and-forward).
- Drops bad frames with a one-cycle error pulse.

Parameters:
DW, 16, data word width (min 8)
MAX_LEN, 8, max payload words per frame (power of two, 2..256)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input word valid
in_ready  out  1  block accepts input word this cycle
in_data  in  DW  input word
out_valid  out  1  output payload word valid
out_ready  in  1  downstream accepts output word
out_data  out  DW  output payload word
out_last  out  1  marks final payload word of frame
err  out  1  one-cycle pulse: frame rejected

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, err=0; state=S_HDR, counters/pointers=0, running checksum=0.
- in_ready is high from the first cycle after rst deasserts.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Frame format:
  - Header word: in_data[7:0] = payload length N; upper bits are don't-care but are included in the checksum.
  - N payload words follow.
  - Checksum word = XOR of the header and all payload words (full DW).
- S_HDR (in_ready=1): on transfer, latch N and set csum = word.
  - N=0: err pulse next cycle, stay S_HDR.
  - N>MAX_LEN: err pulse, go to S_DROP with skip count N+1.
  - Otherwise go to S_PAY.
- S_PAY (in_ready=1): each transfer writes buf[wptr], wptr++, csum ^= word. After the Nth word go to S_CSUM.
- S_CSUM (in_ready=1): on transfer compare the word to csum.
  - Match: go to S_SEND with rptr=0.
  - Mismatch: err pulse the next cycle, go to S_HDR. No out_valid is ever raised for the frame.
- S_SEND (in_ready=0):
  - out_valid is registered. The first word is presented the cycle after the checksum transfer.
  - out_data=buf[rptr], held stable while out_valid && !out_ready.
  - out_last=1 when rptr==N-1.
  - On the last transfer, deassert out_valid and return to S_HDR; in_ready rises the next cycle.
  - No bubbles between words while out_ready stays high.
- S_DROP (in_ready=1): discard words without checksum tracking, decrementing the count; return to S_HDR after the final one.
- err is registered, exactly 1 cycle wide per rejected frame. Never asserted in S_SEND.
- Pointers are $clog2(MAX_LEN) bits wide. Length comparisons use the full 8-bit N.
- N==MAX_LEN must not overflow into the next frame's state.
- in_valid deasserting mid-frame is legal: state holds, no timeout.
- rst asserted mid-frame or mid-send: immediate return to reset values; the partial frame is lost. The buffer contents are not cleared.

Optional Feature:
- Macro FRAME_RX_STATS_EN.
- Defined: adds output ports ok_cnt[15:0] and err_cnt[15:0], reset to 0.
  - ok_cnt increments on each last output transfer.
  - err_cnt increments on each err pulse.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package frame_pkg:
  - state_e enum (S_HDR, S_PAY, S_CSUM, S_SEND, S_DROP), typed state_t.
  - LEN_W=8 and a length_t typedef.
  - Function frame_csum() for the bench model.
- One natural sub-module, frame_rx_buf: a MAX_LEN x DW register-file with write port and registered read port. The FSM stays in frame_rx.

Test Plan:
- Good frame: send 0x0003, 0x0011, 0x0022, 0x0033, 0x0003 -> out 0x0011, 0x0022, 0x0033 on consecutive cycles with out_ready=1, out_last only on 0x0033, err=0.
- Bad checksum: same frame with checksum 0x0004 -> err high exactly 1 cycle, out_valid never asserts, next good frame passes.
- Zero length then oversize: 0x0000 -> err pulse; then 0x0009 (MAX_LEN=8) followed by 10 words -> err pulse, all 10 dropped, following frame 0x0001, 0x00AA, 0x00AB -> out 0x00AA with out_last.
- Backpressure: good 8-word frame, out_ready toggled 1010... -> out_data stable while stalled, in_ready=0 throughout S_SEND, all 8 words in order.
- Reset mid-payload: assert rst after 2 of 3 payload words -> all outputs 0 immediately; after release, new frame 0x0001, 0x0055, 0x0054 -> out 0x0055 with out_last.
- FRAME_RX_STATS_EN build: 3 good + 2 bad frames -> ok_cnt=3, err_cnt=2.
